inst_cache: RTL and testbench



---
 rtl/ic_pkg.sv | 17 +
 rtl/inst_cache_array.sv | 57 +++++
 rtl/inst_cache.sv | 129 ++++++++++++
 tb/tb_inst_cache.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// Shared types and line geometry for the instruction cache.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: LINE_WORDS / LINE_BITS line geometry and the fill FSM state type.
package ic_pkg;

  localparam int LINE_WORDS = 4;
  localparam int LINE_BITS  = 128;

  typedef enum logic [1:0] {
    IC_IDLE,
    IC_REQ,
    IC_FILL,
    IC_INSTALL
  } ic_state_t;

endpackage

// File: rtl/inst_cache_array.sv
// Tag/data/valid storage for the direct-mapped instruction cache.
// Latency: combinational read, write and flush take effect at the next clk edge.
// Backpressure: none; writes and flushes are always accepted.
// Ports: clk/reset; rd_idx -> rd_valid/rd_tag/rd_data; wr_en/wr_idx/wr_tag/wr_data
//        install one line; flush clears every valid bit (a same-cycle write stays valid).
module inst_cache_array
  import ic_pkg::*;
#(
  parameter  int NUM_LINES = 64,
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int TAG_W     = 28 - IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_W-1:0]     rd_idx,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_BITS-1:0] wr_data,
  input  logic                 flush,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_BITS-1:0] data_mem [NUM_LINES];

  // The write is applied after the flush so an install coinciding with a
  // flush leaves its own line valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= '0;
      end
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // Tag and data need no reset: they are only trusted behind valid_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache feeding the IFQ with whole 4-word lines.
// Latency: hits return in the same cycle; a miss costs REQ + grant wait + 4 beats + INSTALL.
// Backpressure: Rd_en gates delivery; misses stall (Busy) until the line is installed.
// Ports: Pc_in/Rd_en/Abort/Flush from IFQ; Dout/Dout_valid to IFQ;
//        Mem_req/Mem_addr/Mem_gnt/Mem_rvalid/Mem_rdata to main memory; Busy = fill in progress.
module inst_cache
  import ic_pkg::*;
#(
  parameter  int NUM_LINES = 64,
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int TAG_W     = 28 - IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Pc_in,
  input  logic                 Rd_en,
  input  logic                 Abort,
  input  logic                 Flush,
  output logic [LINE_BITS-1:0] Dout,
  output logic                 Dout_valid,
  output logic                 Mem_req,
  output logic [31:0]          Mem_addr,
  input  logic                 Mem_gnt,
  input  logic                 Mem_rvalid,
  input  logic [31:0]          Mem_rdata,
  output logic                 Busy
);

  ic_state_t            state;
  logic [27:0]          miss_line;   // Pc[31:4] of the line being filled
  logic [1:0]           cnt;         // next beat slot in linebuf
  logic [LINE_BITS-1:0] linebuf;

  logic [IDX_W-1:0]     pc_idx;
  logic [TAG_W-1:0]     pc_tag;
  logic                 arr_valid;
  logic [TAG_W-1:0]     arr_tag;
  logic [LINE_BITS-1:0] arr_data;
  logic                 hit;
  logic                 miss;
  logic                 install;
  logic                 unused_offset;

  assign pc_idx        = Pc_in[IDX_W+3:4];
  assign pc_tag        = Pc_in[31:IDX_W+4];
  // Byte/word offset is resolved by the IFQ word mux, not here.
  assign unused_offset = ^Pc_in[3:0];

  assign install = (state == IC_INSTALL);

  inst_cache_array #(
    .NUM_LINES (NUM_LINES)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pc_idx),
    .wr_en    (install),
    .wr_idx   (miss_line[IDX_W-1:0]),
    .wr_tag   (miss_line[27:IDX_W]),
    .wr_data  (linebuf),
    .flush    (Flush),
    .rd_valid (arr_valid),
    .rd_tag   (arr_tag),
    .rd_data  (arr_data)
  );

  assign hit  = arr_valid && (arr_tag == pc_tag);
  assign miss = Rd_en && !hit && !Abort && !Flush;

  // Zero-latency delivery so the IFQ can advance Pc_in in the hit cycle.
  assign Dout       = arr_data;
  assign Dout_valid = Rd_en && hit && (state == IC_IDLE) && !Abort && !Flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IC_IDLE;
      miss_line <= '0;
      cnt       <= '0;
      linebuf   <= '0;
      Mem_req   <= 1'b0;
      Mem_addr  <= '0;
      Busy      <= 1'b0;
    end else begin
      case (state)
        IC_IDLE: begin
          if (miss) begin
            miss_line <= Pc_in[31:4];
            Mem_addr  <= {Pc_in[31:4], 4'b0000};
            Mem_req   <= 1'b1;
            Busy      <= 1'b1;
            state     <= IC_REQ;
          end
        end
        IC_REQ: begin
          // A grant commits the transaction even if a redirect arrives with it.
          if (Mem_gnt) begin
            Mem_req <= 1'b0;
            cnt     <= '0;
            state   <= IC_FILL;
          end else if (Abort) begin
            Mem_req <= 1'b0;
            Busy    <= 1'b0;
            state   <= IC_IDLE;
          end
        end
        IC_FILL: begin
          // Abort/Flush deliberately ignored: memory will send all 4 beats.
          if (Mem_rvalid) begin
            linebuf[cnt*32 +: 32] <= Mem_rdata;
            cnt                   <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state <= IC_INSTALL;
            end
          end
        end
        IC_INSTALL: begin
          Busy  <= 1'b0;
          state <= IC_IDLE;
        end
        default: begin
          Mem_req <= 1'b0;
          Busy    <= 1'b0;
          state   <= IC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: line-level cache model plus directed scenarios.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_inst_cache;

  localparam int NL = 64;

  logic         clk;
  logic         reset;
  logic [31:0]  Pc_in;
  logic         Rd_en;
  logic         Abort;
  logic         Flush;
  logic [127:0] Dout;
  logic         Dout_valid;
  logic         Mem_req;
  logic [31:0]  Mem_addr;
  logic         Mem_gnt;
  logic         Mem_rvalid;
  logic [31:0]  Mem_rdata;
  logic         Busy;

  inst_cache #(.NUM_LINES(NL)) dut (
    .clk        (clk),
    .reset      (reset),
    .Pc_in      (Pc_in),
    .Rd_en      (Rd_en),
    .Abort      (Abort),
    .Flush      (Flush),
    .Dout       (Dout),
    .Dout_valid (Dout_valid),
    .Mem_req    (Mem_req),
    .Mem_addr   (Mem_addr),
    .Mem_gnt    (Mem_gnt),
    .Mem_rvalid (Mem_rvalid),
    .Mem_rdata  (Mem_rdata),
    .Busy       (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit started = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cache contents are kept as "which line address lives in each slot".
  bit           mvalid [NL];
  logic [27:0]  mline  [NL];
  logic [127:0] mdata  [NL];
  // Outstanding miss: 0 none, 1 awaiting grant, 2 receiving beats, 3 writing line.
  int           m_phase;
  logic [27:0]  m_line;
  logic [31:0]  m_words [4];
  int           m_beats;

  function automatic int slot_of(input logic [27:0] line);
    return int'(line % NL);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int s;
    s = slot_of(pc[31:4]);
    return mvalid[s] && (mline[s] == pc[31:4]);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NL; i++) mvalid[i] = 0;
      m_phase = 0;
      m_beats = 0;
    end else begin
      bit writing;
      writing = (m_phase == 3);
      if (m_phase == 0) begin
        if (Rd_en && !model_hit(Pc_in) && !Abort && !Flush) begin
          m_line  = Pc_in[31:4];
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (Mem_gnt) begin
          m_phase = 2;
          m_beats = 0;
        end else if (Abort) begin
          m_phase = 0;
        end
      end else if (m_phase == 2) begin
        if (Mem_rvalid) begin
          m_words[m_beats] = Mem_rdata;
          m_beats++;
          if (m_beats == 4) m_phase = 3;
        end
      end else begin
        m_phase = 0;
      end
      if (Flush) begin
        for (int i = 0; i < NL; i++) mvalid[i] = 0;
      end
      if (writing) begin
        mvalid[slot_of(m_line)] = 1;
        mline[slot_of(m_line)]  = m_line;
        mdata[slot_of(m_line)]  = {m_words[3], m_words[2], m_words[1], m_words[0]};
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      bit exp_dv;
      exp_dv = !reset && Rd_en && (m_phase == 0) && model_hit(Pc_in) && !Abort && !Flush;
      check("dout_valid", Dout_valid, exp_dv);
      check("busy", Busy, m_phase != 0);
      check("mem_req", Mem_req, m_phase == 1);
      if (m_phase == 1) check("mem_addr", Mem_addr, {m_line, 4'b0000});
      if (exp_dv) check("dout", Dout, mdata[slot_of(Pc_in[31:4])]);
    end
  end

  // ---------------- stimulus ----------------
  logic         s_dv;
  logic [127:0] s_dout;
  logic         s_req;
  logic         s_busy;

  task automatic cyc(input logic [31:0] pc, input logic rd, input logic ab, input logic fl,
                     input logic gnt, input logic rv, input logic [31:0] rdata);
    Pc_in = pc; Rd_en = rd; Abort = ab; Flush = fl;
    Mem_gnt = gnt; Mem_rvalid = rv; Mem_rdata = rdata;
    @(negedge clk);
    s_dv = Dout_valid; s_dout = Dout; s_req = Mem_req; s_busy = Busy;
    @(posedge clk);
    #1;
  endtask

  // Miss on pc, wait gnt_wait cycles, grant, 4 beats, install. Pc_in wanders
  // during the fill and stray rvalids are sent while waiting for grant.
  task automatic miss_fill(input logic [31:0] pc, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3, input int gnt_wait,
                           input bit ab_gnt, input bit ab_fill, input bit fl_inst,
                           output logic [31:0] gaddr);
    logic [31:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    cyc(pc, 1, 0, 0, 0, 0, 32'h0);
    check("miss_no_valid", s_dv, 1'b0);
    for (int i = 0; i < gnt_wait; i++) cyc(pc ^ 32'h1000, 1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    Pc_in = pc ^ 32'h2000; Rd_en = 1; Abort = ab_gnt; Flush = 0;
    Mem_gnt = 1; Mem_rvalid = 0; Mem_rdata = 32'h0;
    @(negedge clk);
    gaddr = Mem_addr;
    check("req_at_grant", Mem_req, 1'b1);
    check("addr_at_grant", Mem_addr, {pc[31:4], 4'b0000});
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cyc(pc ^ 32'h3000, 1, ab_fill, 0, 0, 1, w[i]);
    cyc(pc, 1, 0, fl_inst, 0, 0, 32'h0);
    check("install_no_valid", s_dv, 1'b0);
    check("install_busy", s_busy, 1'b1);
  endtask

  logic [31:0] ga;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; Pc_in = 32'h40; Rd_en = 1; Abort = 0; Flush = 0;
    Mem_gnt = 0; Mem_rvalid = 0; Mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_dv", Dout_valid, 1'b0);
    check("reset_req", Mem_req, 1'b0);
    check("reset_addr", Mem_addr, 32'h0);
    check("reset_busy", Busy, 1'b0);
    @(posedge clk);
    #1;
    reset = 0;
    started = 1;

    // Cold miss with literal line and address; hit follows 7 cycles after the miss.
    miss_fill(32'h40, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0, ga);
    check("cold_mem_addr", ga, 32'h0000_0040);
    cyc(32'h40, 1, 0, 0, 0, 0, 0);
    check("cold_hit_valid", s_dv, 1'b1);
    check("cold_hit_data", s_dout, 128'h00000044_00000033_00000022_00000011);
    cyc(32'h4C, 1, 0, 0, 0, 0, 0);
    check("hit_4c_valid", s_dv, 1'b1);
    check("hit_4c_data", s_dout, 128'h00000044_00000033_00000022_00000011);
    cyc(32'h44, 0, 0, 0, 0, 0, 0);
    check("hit_no_req", s_req, 1'b0);
    check("rd_en_low", s_dv, 1'b0);

    // Conflict miss on slot 4 (tag 1), then the original line misses again.
    miss_fill(32'h440, 32'h55, 32'h66, 32'h77, 32'h88, 2, 0, 0, 0, ga);
    cyc(32'h448, 1, 0, 0, 0, 0, 0);
    check("conflict_hit", s_dout, 128'h00000088_00000077_00000066_00000055);
    miss_fill(32'h40, 32'h11, 32'h22, 32'h33, 32'h44, 1, 0, 0, 0, ga);
    cyc(32'h440, 1, 0, 0, 0, 0, 0);
    check("evicted_miss", s_dv, 1'b0);
    cyc(32'h440, 1, 1, 0, 0, 0, 0);

    // Abort in REQ before grant: request drops, line 4 still served.
    cyc(32'h80, 1, 0, 0, 0, 0, 0);
    cyc(32'h80, 1, 1, 0, 0, 0, 0);
    check("abort_req_still_high", s_req, 1'b1);
    cyc(32'h40, 1, 0, 0, 0, 0, 0);
    check("abort_req_dropped", s_req, 1'b0);
    check("abort_idle", s_busy, 1'b0);
    check("abort_line4_kept", s_dv, 1'b1);

    // Abort with the grant, and abort throughout the fill: both still install.
    miss_fill(32'h80, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 1, 0, 0, ga);
    cyc(32'h80, 1, 0, 0, 0, 0, 0);
    check("abort_gnt_hit", s_dout, 128'h000000A3_000000A2_000000A1_000000A0);
    miss_fill(32'hC0, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 0, 0, 1, 0, ga);
    cyc(32'hC4, 1, 0, 0, 0, 0, 0);
    check("abort_fill_hit", s_dv, 1'b1);

    // One-cycle flush: all three lines miss afterwards.
    cyc(32'h40, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      logic [31:0] a;
      a = 32'h40 * i;
      cyc(a, 1, 0, 0, 0, 0, 0);
      check("flush_miss_valid", s_dv, 1'b0);
      cyc(a, 1, 1, 0, 0, 0, 0);
      check("flush_miss_req", s_req, 1'b1);
    end

    // Flush during INSTALL: only the line being installed survives.
    miss_fill(32'h100, 32'h1, 32'h2, 32'h3, 32'h4, 0, 0, 0, 0, ga);
    miss_fill(32'h40, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 1, ga);
    cyc(32'h40, 1, 0, 0, 0, 0, 0);
    check("flush_inst_kept", s_dv, 1'b1);
    cyc(32'h100, 1, 0, 0, 0, 0, 0);
    check("flush_inst_other_gone", s_dv, 1'b0);
    cyc(32'h100, 1, 1, 0, 0, 0, 0);

    // Reset after two beats of a fill.
    cyc(32'h200, 1, 0, 0, 0, 0, 0);
    cyc(32'h200, 1, 0, 0, 1, 0, 0);
    cyc(32'h200, 1, 0, 0, 0, 1, 32'h9);
    cyc(32'h200, 1, 0, 0, 0, 1, 32'h8);
    reset = 1; Pc_in = 32'h40; Rd_en = 1; Mem_rvalid = 0;
    #2;
    check("midfill_reset_req", Mem_req, 1'b0);
    check("midfill_reset_busy", Busy, 1'b0);
    check("midfill_reset_dv", Dout_valid, 1'b0);
    @(posedge clk);
    #1;
    reset = 0;
    cyc(32'h40, 1, 0, 0, 0, 0, 0);
    check("post_reset_miss", s_dv, 1'b0);
    cyc(32'h40, 1, 1, 0, 0, 0, 0);
    check("post_reset_req", s_req, 1'b1);
    cyc(32'h40, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
